// File: rtl/sample_pkg.sv
// Shared sample payload and I2S frame defaults for the codec-side transmitter and receiver.
package sample_pkg;

    localparam int unsigned SAMPLE_W          = 24;
    localparam int unsigned I2S_SLOT_BITS     = 32;
    localparam int unsigned I2S_SCLK_HALF_DIV = 4;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] lc;
        logic signed [SAMPLE_W-1:0] rc;
    } sample_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bit clock, word select and slot bit counter derived from the system clock.
module i2s_clk_gen
    import sample_pkg::*;
#(
    parameter int unsigned SLOT_BITS     = I2S_SLOT_BITS,
    parameter int unsigned SCLK_HALF_DIV = I2S_SCLK_HALF_DIV,
    localparam int unsigned CNT_W        = $clog2(2 * SLOT_BITS),
    localparam int unsigned DIV_W        = (SCLK_HALF_DIV > 1) ? $clog2(SCLK_HALF_DIV) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             sclk,
    output logic             lrck,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             fall_c,
    output logic             wrap_c
);

    logic [DIV_W-1:0] div_cnt;
    logic             div_term_c;
    logic [CNT_W-1:0] bit_nxt_c;

    always_comb begin
        div_term_c = (div_cnt == DIV_W'(SCLK_HALF_DIV - 1));
        fall_c     = div_term_c & sclk;
        wrap_c     = fall_c & (bit_cnt == CNT_W'(2 * SLOT_BITS - 1));
        bit_nxt_c  = (bit_cnt == CNT_W'(2 * SLOT_BITS - 1)) ? '0 : bit_cnt + CNT_W'(1);
    end

    // Bit count and word select move together on the SCLK falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            bit_cnt <= '0;
            lrck    <= 1'b0;
        end else begin
            if (div_term_c) begin
                div_cnt <= '0;
                sclk    <= ~sclk;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (fall_c) begin
                bit_cnt <= bit_nxt_c;
                lrck    <= (bit_nxt_c >= CNT_W'(SLOT_BITS));
            end
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry sample buffer, frame register and MSB-first serializer to the DAC.
module i2s_tx
    import sample_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = SAMPLE_W,
    parameter int unsigned SLOT_BITS     = I2S_SLOT_BITS,
    parameter int unsigned SCLK_HALF_DIV = I2S_SCLK_HALF_DIV
) (
    input  logic    clk,
    input  logic    rst,
    input  sample_t data_i,
    input  logic    vld_i,
    output logic    rdy_o,
    output logic    sclk_o,
    output logic    lrck_o,
    output logic    sdata_o,
    output logic    underrun_o
);

    localparam int unsigned CNT_W = $clog2(2 * SLOT_BITS);
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

    logic [CNT_W-1:0]      bit_cnt;
    logic                  fall_c;
    logic                  wrap_c;
    logic [CNT_W-1:0]      bit_nxt_c;
    logic [CNT_W-1:0]      pos_c;
    logic                  right_c;
    logic [DATA_WIDTH-1:0] word_c;
    logic [IDX_W-1:0]      idx_c;
    logic                  bit_c;
    sample_t               buf_q;
    sample_t               frame_q;

    i2s_clk_gen #(
        .SLOT_BITS     (SLOT_BITS),
        .SCLK_HALF_DIV (SCLK_HALF_DIV)
    ) u_clk_gen (
        .clk     (clk),
        .rst     (rst),
        .sclk    (sclk_o),
        .lrck    (lrck_o),
        .bit_cnt (bit_cnt),
        .fall_c  (fall_c),
        .wrap_c  (wrap_c)
    );

    // Bit for the slot position about to start; position 0 is the I2S one-bit delay.
    always_comb begin
        bit_nxt_c = wrap_c ? '0 : bit_cnt + CNT_W'(1);
        right_c   = (bit_nxt_c >= CNT_W'(SLOT_BITS));
        pos_c     = right_c ? bit_nxt_c - CNT_W'(SLOT_BITS) : bit_nxt_c;
        word_c    = right_c ? frame_q.rc : frame_q.lc;
        idx_c     = IDX_W'(CNT_W'(DATA_WIDTH) - pos_c);
        bit_c     = 1'b0;
        if ((pos_c != '0) && (pos_c <= CNT_W'(DATA_WIDTH))) begin
            bit_c = word_c[idx_c];
        end
    end

    // rdy_o doubles as the buffer-empty flag; load and accept are mutually exclusive on it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q      <= '0;
            frame_q    <= '0;
            rdy_o      <= 1'b1;
            sdata_o    <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            underrun_o <= wrap_c & rdy_o;
            if (wrap_c && !rdy_o) begin
                frame_q <= buf_q;
                rdy_o   <= 1'b1;
            end else if (vld_i && rdy_o) begin
                buf_q <= data_i;
                rdy_o <= 1'b0;
            end
            if (fall_c) begin
                sdata_o <= bit_c;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized bench for i2s_tx against a cycle-count based model of the I2S frame.
module tb_i2s_tx;
    import sample_pkg::*;

    localparam int unsigned HALF  = I2S_SCLK_HALF_DIV;
    localparam int unsigned SLOT  = I2S_SLOT_BITS;
    localparam int unsigned FRAME = 4 * SLOT * HALF;

    logic    clk = 1'b0;
    logic    rst;
    sample_t data_i;
    logic    vld_i;
    logic    rdy_o;
    logic    sclk_o;
    logic    lrck_o;
    logic    sdata_o;
    logic    underrun_o;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    int unsigned n;
    sample_t     m_frm;
    sample_t     m_buf;
    bit          m_full;
    logic        prev_sdata;
    logic        prev_lrck;

    always #5 clk = ~clk;

    i2s_tx dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .vld_i      (vld_i),
        .rdy_o      (rdy_o),
        .sclk_o     (sclk_o),
        .lrck_o     (lrck_o),
        .sdata_o    (sdata_o),
        .underrun_o (underrun_o)
    );

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    // Serial bit expected after n clk edges, from the frame in force.
    function automatic logic exp_sdata(input int unsigned cyc, input sample_t frm);
        int unsigned b;
        int unsigned p;
        logic [SAMPLE_W-1:0] word;
        b    = (cyc / (2 * HALF)) % (2 * SLOT);
        p    = b % SLOT;
        word = (b >= SLOT) ? frm.rc : frm.lc;
        if (p >= 1 && p <= SAMPLE_W) return word[SAMPLE_W - p];
        return 1'b0;
    endfunction

    function automatic sample_t rnd_sample();
        sample_t s;
        s.lc = 24'($urandom);
        s.rc = 24'($urandom);
        return s;
    endfunction

    task automatic model_reset();
        n          = 0;
        m_frm      = '0;
        m_buf      = '0;
        m_full     = 1'b0;
        prev_sdata = 1'b0;
        prev_lrck  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_sclk"},     48'(sclk_o),     48'(0));
        check_eq({tag, "_lrck"},     48'(lrck_o),     48'(0));
        check_eq({tag, "_sdata"},    48'(sdata_o),    48'(0));
        check_eq({tag, "_rdy"},      48'(rdy_o),      48'(1));
        check_eq({tag, "_underrun"}, 48'(underrun_o), 48'(0));
    endtask

    task automatic step();
        logic exp_und;
        int unsigned b;
        @(posedge clk);
        n++;
        exp_und = 1'b0;
        if ((n % FRAME == 0) && m_full) begin
            m_frm  = m_buf;
            m_full = 1'b0;
        end else begin
            if (n % FRAME == 0) exp_und = 1'b1;
            if (vld_i && !m_full) begin
                m_buf  = data_i;
                m_full = 1'b1;
            end
        end
        #1;
        b = (n / (2 * HALF)) % (2 * SLOT);
        check_eq("sclk",     48'(sclk_o),     48'((n / HALF) % 2));
        check_eq("lrck",     48'(lrck_o),     48'(b >= SLOT));
        check_eq("sdata",    48'(sdata_o),    48'(exp_sdata(n, m_frm)));
        check_eq("rdy",      48'(rdy_o),      48'(!m_full));
        check_eq("underrun", 48'(underrun_o), 48'(exp_und));
        if ((n % (2 * HALF) == HALF) || (n % (2 * HALF) == HALF + 1)) begin
            check_eq("sdata_stable_rise", 48'(sdata_o), 48'(prev_sdata));
            check_eq("lrck_stable_rise",  48'(lrck_o),  48'(prev_lrck));
        end
        prev_sdata = sdata_o;
        prev_lrck  = lrck_o;
    endtask

    task automatic run_cycles(input int unsigned k);
        repeat (k) step();
    endtask

    task automatic run_to(input int unsigned pos);
        while ((n % FRAME) != pos) step();
    endtask

    task automatic send(input sample_t s);
        data_i = s;
        vld_i  = 1'b1;
        step();
        vld_i  = 1'b0;
    endtask

    initial begin
        sample_t s;
        rst    = 1'b0;
        vld_i  = 1'b0;
        data_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;

        // Idle frames: zeros out, one underrun per frame.
        run_cycles(2 * FRAME);

        // Extreme-value sample straddling sign bits.
        run_to(100);
        s.lc = 24'h800001;
        s.rc = 24'h7FFFFE;
        send(s);
        run_cycles(2 * FRAME);

        // Second valid within one frame is dropped.
        run_to(200);
        send(rnd_sample());
        run_cycles(3);
        send(rnd_sample());
        run_cycles(2 * FRAME);

        // Starved pipeline repeats the last word.
        run_to(50);
        s    = rnd_sample();
        s.lc = 24'h123456;
        send(s);
        run_cycles(3 * FRAME);

        // Sparse random traffic.
        for (int i = 0; i < int'(4 * FRAME); i++) begin
            vld_i  = ($urandom_range(0, 299) == 0);
            data_i = rnd_sample();
            step();
        end
        vld_i = 1'b0;

        // Asynchronous reset in the middle of the right slot.
        run_to(FRAME / 2 + 44);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("mid_rst_hold");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        send(rnd_sample());
        run_cycles(2 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
